// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
package sevenseg_pkg;
  typedef logic [6:0] seg_t;        // {g,f,e,d,c,b,a}, active-low
  typedef logic [1:0] digit_idx_t;

  localparam int   NUM_DIGITS = 3;
  localparam seg_t SEG_BLANK  = 7'b1111111;
  localparam seg_t SEG_DASH   = 7'b0111111;
endpackage

// File: rtl/sevenseg_scan_if.sv
// Digit inputs, freeze control and display bus of the scanner.
interface sevenseg_scan_if;
  import sevenseg_pkg::*;
  logic [3:0] y2, y1, y0;
  logic       freeze;
  seg_t       seg;
  logic [2:0] an;

  modport master (output y2, y1, y0, freeze, input seg, an);
  modport slave  (input y2, y1, y0, freeze, output seg, an);
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; 10..15 show a dash.
module bcd_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);
  // Digit glyph lookup
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = 7'b1000000;
      4'd1: o_seg = 7'b1111001;
      4'd2: o_seg = 7'b0100100;
      4'd3: o_seg = 7'b0110000;
      4'd4: o_seg = 7'b0011001;
      4'd5: o_seg = 7'b0010010;
      4'd6: o_seg = 7'b0000010;
      4'd7: o_seg = 7'b1111000;
      4'd8: o_seg = 7'b0000000;
      4'd9: o_seg = 7'b0010000;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/sevenseg_scan.sv
// Three-digit time-multiplexed 7-segment scanner with per-frame snapshot
// and freeze (lap-hold). Optional leading-zero blanking via the
// SEG_BLANK_LEADING_EN macro.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  sevenseg_scan_if.slave  bus
);
  localparam int                CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]     DIV_MAX = CW'(REFRESH_DIV - 1);
  localparam digit_idx_t        IDX_MAX = digit_idx_t'(NUM_DIGITS - 1);

  logic [CW-1:0]                  r_div_cnt;
  digit_idx_t                     r_idx;
  logic [NUM_DIGITS-1:0][3:0]     r_snap;
  seg_t                           r_seg;
  logic [NUM_DIGITS-1:0]          r_an;

  logic [NUM_DIGITS-1:0][3:0]     w_live, w_src;
  digit_idx_t                     w_sel;
  logic                           w_idx_ok, w_frame, w_load, w_blank;
  logic [3:0]                     w_dig;
  seg_t                           w_dec, w_seg_nxt;
  logic [NUM_DIGITS-1:0]          w_an_nxt;

  assign w_live   = {bus.y2, bus.y1, bus.y0};
  assign w_idx_ok = (r_idx <= IDX_MAX);
  assign w_sel    = w_idx_ok ? r_idx : '0;
  assign w_frame  = (r_idx == '0) && (r_div_cnt == '0);
  assign w_load   = w_frame && !bus.freeze;
  // On a loading frame start the live digits bypass the snapshot so the new
  // frame shows fresh data without an extra cycle of delay.
  assign w_src    = w_load ? w_live : r_snap;
  assign w_dig    = w_src[w_sel];

  bcd_to_seg u_dec (.i_bcd(w_dig), .o_seg(w_dec));

`ifdef SEG_BLANK_LEADING_EN
  logic [NUM_DIGITS-1:0] w_zero;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_zero
    assign w_zero[g] = (w_src[g] == 4'd0);
  end
  assign w_blank = ((w_sel == digit_idx_t'(2)) && w_zero[2]) ||
                   ((w_sel == digit_idx_t'(1)) && w_zero[2] && w_zero[1]);
`else
  assign w_blank = 1'b0;
`endif

  // Next segment/anode pattern for the digit selected this cycle
  always_comb begin
    w_seg_nxt = w_dec;
    w_an_nxt  = ~(NUM_DIGITS'(1) << w_sel);
    if (!w_idx_ok) begin
      w_seg_nxt = SEG_BLANK;
      w_an_nxt  = '1;
    end else if (w_blank) begin
      w_seg_nxt = SEG_BLANK;
    end
  end

  // Refresh divider and digit index; an illegal index recovers to digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (!w_idx_ok) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (r_div_cnt == DIV_MAX) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IDX_MAX) ? '0 : r_idx + digit_idx_t'(1);
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  // Frame snapshot, loaded only at frame start when not frozen
  always_ff @(posedge clk) begin
    if (rst)         r_snap <= '0;
    else if (w_load) r_snap <= w_live;
  end

  // Registered display outputs, blank while in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
endmodule
